onehot_scan_encoder: RTL

Parametrised, sequential successor to the fixed 64-to-6 one-hot encoder. It accepts an N-bit request vector with any number of bits set, then emits the binary index of every set bit, one index per output handshake. Scan order is selectable at elaboration. It sits between request/flag collectors and index-consuming logic (table lookup, arbitration grant decode), where multi-hot inputs must be serialised rather than OR-merged.

---
 rtl/onehot_scan_encoder.sv | 95 +++++++++
 1 files changed

// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder: serialises a multi-hot request vector into
// one binary index per output handshake, in a fixed scan order.
module onehot_scan_encoder #(
   parameter int N         = 64,
   parameter bit LSB_FIRST = 1'b1,
   localparam int W        = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_zero
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t         r_state;
   logic [N-1:0]   r_pend;
   logic           r_zflag;

   logic [W-1:0]   w_idx;
   logic           w_found;
   logic           w_multi;
   logic           w_xfer;
   logic [N-1:0]   w_clr;

   // priority encode of pend in the configured scan order
   always_comb begin
      int j;
      j       = 0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = LSB_FIRST ? i : (N - 1 - i);
         if (!w_found && r_pend[j]) begin
            w_idx   = W'(j);
            w_found = 1'b1;
         end
      end
   end

   assign w_multi   = |(r_pend & (r_pend - N'(1)));
   assign w_clr     = N'(1) << w_idx;

   assign out_valid = (r_state == SCAN);
   assign out_idx   = out_valid ? w_idx : '0;
   assign out_last  = out_valid && !w_multi;
   assign out_zero  = out_valid && r_zflag;

   assign w_xfer    = out_valid && out_ready;
   assign in_ready  = (r_state == IDLE) || (w_xfer && out_last);

   // scan state machine: load on accept, retire one bit per transfer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pend  <= '0;
         r_zflag <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_pend  <= in_vec;
                  r_zflag <= (in_vec == '0);
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (w_xfer) begin
                  if (!out_last) begin
                     r_pend <= r_pend & ~w_clr;
                  end else if (in_valid) begin
                     r_pend  <= in_vec;
                     r_zflag <= (in_vec == '0);
                  end else begin
                     r_pend  <= '0;
                     r_zflag <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
